// File: rtl/alm_mac_drain_if.sv
// ---------------------------------------------------------------------------
// alm_mac_drain_if
// Bundles the MAC-side issue/accumulator signals and the requantised
// result stream of the ALM MAC drain stage.
//   mac_valid  : operand pair issued to the MAC this cycle
//   in_ready   : upstream may issue
//   acc_en     : MAC control, 0 = load product, 1 = accumulate
//   result     : 27-bit signed MAC accumulator
//   shamt      : requant right-shift amount
//   out_data   : requantised signed 8-bit dot product (FIFO head)
//   out_valid  : FIFO non-empty
//   out_ready  : consumer accepts the head
// master = producer/consumer environment, slave = drain stage.
// ---------------------------------------------------------------------------
interface alm_mac_drain_if;
    logic               mac_valid;
    logic               in_ready;
    logic               acc_en;
    logic signed [26:0] result;
    logic        [4:0]  shamt;
    logic signed [7:0]  out_data;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output mac_valid, result, shamt, out_ready,
        input  in_ready, acc_en, out_data, out_valid
    );

    modport slave (
        input  mac_valid, result, shamt, out_ready,
        output in_ready, acc_en, out_data, out_valid
    );
endinterface

// File: rtl/alm_mac_drain.sv
// ---------------------------------------------------------------------------
// alm_mac_drain
// Drain stage for the 8-bit ALM MAC. Counts issued operand pairs, drives
// acc_en so every DOT_LEN products form one dot product, captures the
// accumulator MAC_LAT cycles after the last issue, requantises it to signed
// 8 bit (arithmetic shift, optional rounding, saturation) and queues it in a
// FIFO. Group starts are credit-gated so a finished result is never dropped.
//
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous active-high reset
//   bus      : alm_mac_drain_if.slave (issue, MAC accumulator, result stream)
//   sat_clr  : synchronous clear of sat_flag
//   sat_flag : sticky, set when any result saturated
//
// Build option: define ALM_DRAIN_ROUND_EN for round-half-up before the shift;
// undefined gives a plain floor shift and no rounding adder.
// ---------------------------------------------------------------------------
module alm_mac_drain #(
    parameter int unsigned DOT_LEN    = 4,
    parameter int unsigned MAC_LAT    = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    alm_mac_drain_if.slave    bus,
    input  logic              sat_clr,
    output logic              sat_flag
);
    localparam int unsigned CNT_W = (DOT_LEN > 1) ? $clog2(DOT_LEN) : 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned SUM_W = OCC_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DOT_LEN - 1);

    logic [CNT_W-1:0]   cnt;
    logic               issue_c;
    logic               last_c;
    logic [MAC_LAT-1:0] tok;

    logic               cap_v;
    logic signed [26:0] cap_res;
    logic        [4:0]  cap_sh;

    logic signed [27:0] wide_c;
    logic signed [7:0]  rq_next_c;
    logic               rq_sat_c;
    logic               rq_v;
    logic signed [7:0]  rq_data;

    logic signed [7:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   fcount;
    logic [OCC_W-1:0]   inflight;
    logic [SUM_W-1:0]   occ_c;
    logic               wr_c;
    logic               rd_c;

    // Issue accounting and credit gate: only a group start can be refused.
    assign issue_c      = bus.mac_valid && bus.in_ready;
    assign last_c       = issue_c && (cnt == CNT_LAST);
    assign occ_c        = SUM_W'(fcount) + SUM_W'(inflight);
    assign bus.in_ready = (cnt != '0) || (occ_c < SUM_W'(FIFO_DEPTH));
    assign bus.acc_en   = (cnt != '0);

    assign wr_c          = rq_v;
    assign rd_c          = bus.out_valid && bus.out_ready;
    assign bus.out_valid = (fcount != '0);
    assign bus.out_data  = mem[rd_ptr];

    // Product index within the current dot product.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (issue_c) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    // Token pipe matching the MAC latency; top bit marks "result is final".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tok <= '0;
        end else begin
            tok <= MAC_LAT'({tok, last_c});
        end
    end

    // Capture accumulator and shift amount when the token emerges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_v   <= 1'b0;
            cap_res <= '0;
            cap_sh  <= '0;
        end else begin
            cap_v <= tok[MAC_LAT-1];
            if (tok[MAC_LAT-1]) begin
                cap_res <= bus.result;
                cap_sh  <= bus.shamt;
            end
        end
    end

    // Requantise: shift (optionally rounded) then clip to signed 8 bit.
    always_comb begin
        wide_c    = 28'(cap_res);
        rq_next_c = '0;
        rq_sat_c  = 1'b0;
`ifdef ALM_DRAIN_ROUND_EN
        // A half-LSB of 2^27 or more always exceeds |result|, so the rounded
        // quotient is 0; this also keeps the offset inside 28 bits.
        if (cap_sh > 5'd27) begin
            wide_c = '0;
        end else begin
            if (cap_sh != 5'd0) begin
                wide_c = wide_c + (28'sd1 <<< (cap_sh - 5'd1));
            end
            wide_c = wide_c >>> cap_sh;
        end
`else
        wide_c = wide_c >>> cap_sh;
`endif
        if (wide_c > 28'sd127) begin
            rq_next_c = 8'h7F;
            rq_sat_c  = 1'b1;
        end else if (wide_c < -28'sd128) begin
            rq_next_c = 8'h80;
            rq_sat_c  = 1'b1;
        end else begin
            rq_next_c = wide_c[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rq_v    <= 1'b0;
            rq_data <= '0;
        end else begin
            rq_v <= cap_v;
            if (cap_v) begin
                rq_data <= rq_next_c;
            end
        end
    end

    // Sticky saturation flag; a new saturation wins over a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_flag <= 1'b0;
        end else if (cap_v && rq_sat_c) begin
            sat_flag <= 1'b1;
        end else if (sat_clr) begin
            sat_flag <= 1'b0;
        end
    end

    // Groups whose last issue is accepted but not yet written to the FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= '0;
        end else begin
            case ({last_c, wr_c})
                2'b10:   inflight <= inflight + OCC_W'(1);
                2'b01:   inflight <= inflight - OCC_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Output FIFO storage and pointers (power-of-two depth, natural wrap).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcount <= '0;
        end else begin
            if (wr_c) begin
                mem[wr_ptr] <= rq_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (rd_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_c, rd_c})
                2'b10:   fcount <= fcount + OCC_W'(1);
                2'b01:   fcount <= fcount - OCC_W'(1);
                default: fcount <= fcount;
            endcase
        end
    end
endmodule

// File: tb/tb_alm_mac_drain.sv
// ---------------------------------------------------------------------------
// tb_alm_mac_drain
// Self-checking bench for alm_mac_drain. A behavioural MAC drives `result`
// from acc_en; expected outputs come from whole-group sums requantised with
// plain integer arithmetic and are kept in a queue in issue order.
// ---------------------------------------------------------------------------
module tb_alm_mac_drain;
    localparam int DOT_LEN    = 4;
    localparam int MAC_LAT    = 1;
    localparam int FIFO_DEPTH = 4;

    logic clk;
    logic reset;
    logic sat_clr;
    logic sat_flag;

    alm_mac_drain_if bus ();

    alm_mac_drain #(
        .DOT_LEN    (DOT_LEN),
        .MAC_LAT    (MAC_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .sat_clr  (sat_clr),
        .sat_flag (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    logic signed [7:0]  pa;
    logic signed [7:0]  pb;
    logic signed [26:0] mac_acc;

    int grp_idx;
    int grp_sum;
    int n_grp_done;
    int n_issue;
    int n_pop;
    bit exp_sat;
    int exp_q[$];

    task automatic chk_eq(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Behavioural MAC with one register of latency.
    assign bus.result = mac_acc;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mac_acc <= '0;
        end else if (bus.mac_valid && bus.in_ready) begin
            mac_acc <= bus.acc_en ? mac_acc + 27'(int'(pa) * int'(pb))
                                  : 27'(int'(pa) * int'(pb));
        end
    end

    function automatic int requant(input int sum, input int sh, output bit clip);
        longint s;
`ifdef ALM_DRAIN_ROUND_EN
        if (sh > 0) s = (longint'(sum) + (longint'(1) << (sh - 1))) >>> sh;
        else        s = longint'(sum);
`else
        s = longint'(sum) >>> sh;
`endif
        clip = 1'b0;
        if (s > 127)  begin s = 127;  clip = 1'b1; end
        if (s < -128) begin s = -128; clip = 1'b1; end
        return int'(s);
    endfunction

    // Consumer-side scoreboard.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            chk_eq("q_nonempty", longint'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                chk_eq("out_data", longint'(bus.out_data), longint'(exp_q[0]));
                void'(exp_q.pop_front());
                n_pop++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One cycle of issue; the model records the pair only if accepted.
    task automatic step(input bit v, input int a, input int b);
        bit clip;
        bus.mac_valid = v;
        pa = 8'(a);
        pb = 8'(b);
        @(negedge clk);
        if (v && bus.in_ready) begin
            chk_eq("acc_en", longint'(bus.acc_en), longint'(grp_idx != 0));
            grp_sum += int'(pa) * int'(pb);
            grp_idx++;
            n_issue++;
            if (grp_idx == DOT_LEN) begin
                exp_q.push_back(requant(grp_sum, int'(bus.shamt), clip));
                exp_sat |= clip;
                grp_idx = 0;
                grp_sum = 0;
                n_grp_done++;
            end
        end
        @(posedge clk);
        #1;
        bus.mac_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        bus.mac_valid = 1'b0;
        bus.out_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.out_valid) && guard < 60) begin
            cyc();
            guard++;
        end
        chk_eq("drain_empty", longint'(exp_q.size()), 0);
        chk_eq("drain_valid", longint'(bus.out_valid), 0);
    endtask

    task automatic clear_sat();
        sat_clr = 1'b1;
        cyc();
        sat_clr = 1'b0;
        exp_sat = 1'b0;
        chk_eq("sat_cleared", longint'(sat_flag), 0);
    endtask

    task automatic pick_byte(output int v);
        case ($urandom_range(0, 5))
            0:       v = 127;
            1:       v = -128;
            default: v = int'($urandom_range(0, 255));
        endcase
    endtask

    task automatic run_rand(input int ngroups, input int pv, input int pr, output int cycles);
        int target = n_grp_done + ngroups;
        int a;
        int b;
        cycles = 0;
        while (n_grp_done < target && cycles < 2000) begin
            bus.out_ready = ($urandom_range(0, 99) < pr);
            pick_byte(a);
            pick_byte(b);
            step($urandom_range(0, 99) < pv, a, b);
            cycles++;
        end
        chk_eq("run_done", n_grp_done, target);
    endtask

    task automatic model_reset();
        grp_idx = 0;
        grp_sum = 0;
        exp_sat = 1'b0;
        exp_q.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_eq({tag, "_in_ready"},  longint'(bus.in_ready), 1);
        chk_eq({tag, "_acc_en"},    longint'(bus.acc_en), 0);
        chk_eq({tag, "_out_valid"}, longint'(bus.out_valid), 0);
        chk_eq({tag, "_out_data"},  longint'(bus.out_data), 0);
        chk_eq({tag, "_sat_flag"},  longint'(sat_flag), 0);
    endtask

    int nom_a[4] = '{4, 8, -99, 65};
    int nom_b[4] = '{7, 9, -70, -121};

    initial begin
        int lat;
        int cycles;
        int start_issue;
        reset         = 1'b1;
        sat_clr       = 1'b0;
        bus.mac_valid = 1'b0;
        bus.shamt     = '0;
        bus.out_ready = 1'b0;
        pa = '0;
        pb = '0;
        n_grp_done = 0;
        n_issue    = 0;
        n_pop      = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        reset = 1'b0;
        cyc();

        // Nominal group with latency measurement.
        bus.shamt = 5'd3;
        for (int i = 0; i < 4; i++) step(1'b1, nom_a[i], nom_b[i]);
        lat = 0;
        @(negedge clk);
        while (!bus.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk_eq("latency", lat, 3);
`ifdef ALM_DRAIN_ROUND_EN
        chk_eq("nominal", longint'(bus.out_data), -104);
`else
        chk_eq("nominal", longint'(bus.out_data), -105);
`endif
        @(posedge clk);
        #1;
        drain();
        chk_eq("nominal_sat", longint'(sat_flag), 0);

        // Negative saturation, then clear.
        bus.shamt = 5'd0;
        for (int i = 0; i < 4; i++) step(1'b1, nom_a[i], nom_b[i]);
        drain();
        chk_eq("neg_sat_flag", longint'(sat_flag), 1);
        clear_sat();

        // Positive clip.
        bus.shamt = 5'd8;
        for (int i = 0; i < 4; i++) step(1'b1, 127, 127);
        drain();
        chk_eq("pos_sat_flag", longint'(sat_flag), 1);
        clear_sat();

        // Backpressure: 4 groups fit, the 5th start is held off.
        bus.shamt     = 5'd6;
        bus.out_ready = 1'b0;
        start_issue   = n_issue;
        for (int i = 0; i < 30; i++) step(1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        chk_eq("bp_issued", n_issue - start_issue, 4 * DOT_LEN);
        chk_eq("bp_in_ready", longint'(bus.in_ready), 0);
        chk_eq("bp_out_valid", longint'(bus.out_valid), 1);
        bus.out_ready = 1'b1;
        cycles = 0;
        while (n_issue - start_issue < 6 * DOT_LEN && cycles < 100) begin
            step(1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            cycles++;
        end
        chk_eq("bp_resumed", n_issue - start_issue, 6 * DOT_LEN);
        drain();
        clear_sat();

        // Sustained throughput with an always-ready consumer.
        bus.shamt = 5'd5;
        run_rand(5, 100, 100, cycles);
        chk_eq("throughput_cycles", cycles, 5 * DOT_LEN);
        drain();
        clear_sat();

        // Reset in the middle of a group.
        bus.shamt     = 5'd4;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, nom_a[i], nom_b[i]);
        step(1'b1, 100, 100);
        step(1'b1, -50, 77);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("midrst");
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc();
        for (int i = 0; i < 4; i++) step(1'b1, nom_b[i], nom_a[i]);
        drain();

        // Randomised phases with random gaps, backpressure and shift.
        for (int p = 0; p < 6; p++) begin
            clear_sat();
            bus.shamt = (p < 4) ? 5'($urandom_range(0, 14)) : 5'($urandom_range(15, 31));
            run_rand(8, 75, 60, cycles);
            drain();
            chk_eq("phase_sat", longint'(sat_flag), longint'(exp_sat));
        end

        chk_eq("pops_seen", longint'(n_pop > 40), 1);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/alm_mac_drain.md
# alm_mac_drain

Downstream drain stage for the 8-bit ALM MAC. It counts operand pairs issued to the MAC and drives the MAC's `acc_en` so each group of DOT_LEN products forms one dot product. After the MAC pipeline latency it captures the 27-bit accumulator, requantises it to signed 8-bit (arithmetic shift, optional rounding, saturation) and queues it in a small FIFO with a valid/ready output. Upstream operand streaming is throttled through `in_ready` so no finished result is ever dropped.

## Interface
- `DOT_LEN`, 4: products per dot product (≥1).
- `MAC_LAT`, 1: cycles from an operand pair being issued to `result` including it (≥1).
- `FIFO_DEPTH`, 4: output FIFO entries (power of two, ≥2).
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `mac_valid` in 1: an operand pair is issued to the MAC this cycle. Ignored when `in_ready`=0.
- `in_ready` out 1: upstream may issue.
- `acc_en` out 1: to the MAC. 0 means load the product, 1 means accumulate.
- `result` in 27 signed: MAC accumulator.
- `shamt` in 5: right-shift amount, sampled at capture.
- `out_data` out 8 signed: requantised dot product, FIFO head.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: consumer accepts the head.
- `sat_flag` out 1: sticky. Set when any result saturated.
- `sat_clr` in 1: synchronous clear of `sat_flag`.

## Operation
- Issue counter `cnt` runs 0..DOT_LEN-1.
  - Advances on an accepted issue (`mac_valid && in_ready`).
  - Wraps to 0 after DOT_LEN-1.
- `acc_en = (cnt != 0)`, combinational from the register. The first product of each group therefore loads the accumulator and clears the previous sum.
- Last issue: accepted issue with `cnt == DOT_LEN-1`. It launches a token into a MAC_LAT-deep shift register.
- Capture: when the token emerges, latch `result` and `shamt`.
- Requant stage (1 register):
  - `s = result >>> shamt`, arithmetic shift.
  - With rounding, `s = (result + (1<<(shamt-1))) >>> shamt` when `shamt>0`. Use a 28-bit intermediate, no overflow.
  - Saturate to [-128, 127].
  - Set `sat_flag` if clipped.
- FIFO write on the cycle after requant.
  - Read on `out_valid && out_ready`.
  - Simultaneous read and write at full or empty are both legal, with count unchanged.
- Credit check:
  - `inflight` = groups whose last issue is accepted but not yet written to the FIFO.
  - `in_ready = (cnt != 0) || (fifo_count + inflight < FIFO_DEPTH)`.
  - Only the start of a new group is blocked. A group in progress is never stalled, so the FIFO cannot overflow.
- `sat_clr` and a saturation event in the same cycle: set wins.
- No state machine beyond `cnt`, the token pipe and the FIFO pointers. DOT_LEN=1 makes every issue a last issue with `acc_en` constantly 0.

## Timing
- Reset values:
  - `cnt`=0, `acc_en`=0.
  - `in_ready`=1.
  - `out_valid`=0, `out_data`=0.
  - `sat_flag`=0.
  - Token pipe, `inflight` and FIFO all cleared.
- Reset mid-operation discards partial groups, in-flight tokens and FIFO contents immediately, asynchronously.
- Latency: with the last issue sampled at edge E, capture is at E+MAC_LAT, requant at E+MAC_LAT+1, and `out_valid` rises after E+MAC_LAT+2 (empty FIFO).
- `out_data` is stable while `out_valid && !out_ready`.
- Throughput: one dot product per DOT_LEN cycles, sustained, with no bubbles when `out_ready`=1.

## Configuration
- `ALM_DRAIN_ROUND_EN`:
  - Defined: round-half-up before the shift, as in Operation.
  - Undefined: plain truncating arithmetic shift (floor). The rounding adder is not built.

## Test plan
- Nominal:
  - Stimulus: DOT_LEN=4, MAC_LAT=1, shamt=3, pairs (4,7), (8,9), (-99,-70), (65,-121); sum -835.
  - Expect `acc_en` sequence 0,1,1,1.
  - Expect `out_data`=-104 with `ALM_DRAIN_ROUND_EN`, -105 without, `out_valid` 3 cycles after the last issue.
- Saturation: same pairs, shamt=0 -> `out_data`=-128, `sat_flag`=1. Then `sat_clr` -> `sat_flag`=0.
- Positive clip: four pairs of (127,127) (sum 64516), shamt=8 -> 252 clipped to 127, `sat_flag`=1.
- Backpressure:
  - Stimulus: `out_ready`=0, stream 6 groups continuously.
  - Expect `in_ready` to drop at the start of group 5, after 4 groups are queued or in flight.
  - Raise `out_ready` -> 4 entries drain in order, then streaming resumes and all 6 results are correct.
- Simultaneous FIFO read/write at full: hold `out_ready`=1 while the FIFO is full and a write arrives -> no loss, count stays 4.
- Reset mid-group:
  - Stimulus: assert `reset` after 2 issues.
  - Expect outputs to return to reset values at once.
  - A new group of 4 yields a correct, independent result with first `acc_en`=0.
